// File: rtl/layer_pkg.sv
// Shared definitions for the inter-layer vector buffer: default word width,
// the signed word type and the counter-width helper.
package layer_pkg;

    localparam int WIDTH_DEF = 16;

    typedef logic signed [WIDTH_DEF-1:0] word_t;

    // Width of a counter that must hold 0..n-1; never narrower than one bit
    // so that VEC=1 or REPEAT=1 still yields a legal register.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vec_bank_rf.sv
// Two-bank vector storage: one synchronous write port, one combinational
// read port. Storage is deliberately not reset; validity is tracked by the
// full flags in the controller.
module vec_bank_rf
    import layer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int VEC   = 8,
    parameter int IW    = idx_w(VEC)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic             i_wr_bank,
    input  logic [IW-1:0]    i_wr_idx,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_bank,
    input  logic [IW-1:0]    i_rd_idx,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [0:1][0:VEC-1];

    // Capture one word into the selected bank/slot on an accepted write.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_bank][i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_bank][i_rd_idx];

endmodule

// File: rtl/layer_vec_pingpong.sv
// Ping-pong inter-layer vector buffer. One bank collects the next VEC-word
// vector from the producing layer while the other bank replays its stored
// vector REPEAT times to the consuming layer. All pointer, full-flag and
// replay control lives here; storage is in vec_bank_rf.
module layer_vec_pingpong
    import layer_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int VEC    = 8,
    parameter int REPEAT = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [WIDTH-1:0] data_in,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [WIDTH-1:0] data_out,
    output logic                    vec_done
);

    localparam int IW = idx_w(VEC);
    localparam int RW = idx_w(REPEAT);

    // Explicit terminal compares so non-power-of-two VEC/REPEAT wrap correctly.
    localparam logic [IW-1:0] LAST_IDX = IW'(VEC - 1);
    localparam logic [RW-1:0] LAST_REP = RW'(REPEAT - 1);

    logic [1:0]    r_full;
    logic          r_wr_bank;
    logic [IW-1:0] r_wr_idx;
    logic          r_rd_bank;
    logic [IW-1:0] r_rd_idx;
    logic [RW-1:0] r_rep_cnt;
    logic          r_vec_done;

    logic             w_s_ready;
    logic             w_m_valid;
    logic             w_wr_fire;
    logic             w_rd_fire;
    logic             w_wr_last;
    logic             w_rd_idx_last;
    logic             w_rd_rep_last;
    logic             w_rd_release;
    logic [1:0]       w_full_set;
    logic [1:0]       w_full_clr;
    logic [1:0]       w_full_nxt;
    logic [WIDTH-1:0] w_rd_data;

    // Ready is held low while reset is asserted so nothing is accepted then.
    assign w_s_ready = reset & ~r_full[r_wr_bank];
    assign w_m_valid = r_full[r_rd_bank];

    assign w_wr_fire     = s_valid & w_s_ready;
    assign w_rd_fire     = w_m_valid & m_ready;
    assign w_wr_last     = (r_wr_idx == LAST_IDX);
    assign w_rd_idx_last = (r_rd_idx == LAST_IDX);
    assign w_rd_rep_last = (r_rep_cnt == LAST_REP);
    assign w_rd_release  = w_rd_fire & w_rd_idx_last & w_rd_rep_last;

    // Full-flag update: set on the write bank when its last word lands, clear
    // on the read bank after its final replay. The two can only ever target
    // opposite banks, so applying both together is safe.
    always_comb begin
        w_full_set = 2'b00;
        w_full_clr = 2'b00;
        if (w_wr_fire && w_wr_last) begin
            w_full_set[r_wr_bank] = 1'b1;
        end
        if (w_rd_release) begin
            w_full_clr[r_rd_bank] = 1'b1;
        end
        w_full_nxt = (r_full | w_full_set) & ~w_full_clr;
    end

    // Bank full flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full <= 2'b00;
        end else begin
            r_full <= w_full_nxt;
        end
    end

    // Write pointer: advance per accepted word, flip bank after the last slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_bank <= 1'b0;
            r_wr_idx  <= '0;
        end else if (w_wr_fire) begin
            if (w_wr_last) begin
                r_wr_bank <= ~r_wr_bank;
                r_wr_idx  <= '0;
            end else begin
                r_wr_idx  <= r_wr_idx + IW'(1);
            end
        end
    end

    // Read pointer and replay counter: walk the vector, restart it until the
    // replay budget is spent, then hand the bank back to the write side.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_bank <= 1'b0;
            r_rd_idx  <= '0;
            r_rep_cnt <= '0;
        end else if (w_rd_fire) begin
            if (!w_rd_idx_last) begin
                r_rd_idx  <= r_rd_idx + IW'(1);
            end else if (!w_rd_rep_last) begin
                r_rd_idx  <= '0;
                r_rep_cnt <= r_rep_cnt + RW'(1);
            end else begin
                r_rd_bank <= ~r_rd_bank;
                r_rd_idx  <= '0;
                r_rep_cnt <= '0;
            end
        end
    end

    // One-cycle completion pulse, registered after the final handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vec_done <= 1'b0;
        end else begin
            r_vec_done <= w_rd_release;
        end
    end

    vec_bank_rf #(
        .WIDTH (WIDTH),
        .VEC   (VEC),
        .IW    (IW)
    ) u_bank_rf (
        .clk       (clk),
        .i_we      (w_wr_fire),
        .i_wr_bank (r_wr_bank),
        .i_wr_idx  (r_wr_idx),
        .i_wr_data (data_in),
        .i_rd_bank (r_rd_bank),
        .i_rd_idx  (r_rd_idx),
        .o_rd_data (w_rd_data)
    );

    assign s_ready  = w_s_ready;
    assign m_valid  = w_m_valid;
    assign data_out = w_m_valid ? $signed(w_rd_data) : '0;
    assign vec_done = r_vec_done;

endmodule
